histogram_engine: RTL

Parametrised streaming histogram engine for the image-processing pipeline. It accepts one pixel per cycle over a valid/ready handshake, bins each pixel into a configurable number of saturating counters, and streams the finished table out as `{bin index, count}` words over a second valid/ready handshake. It replaces the fixed 256-bin, fixed-frame-size histogram task. It adds back-to-back throughput, re-clear per frame, a bin-coarsening option and counter saturation.

---
 rtl/histogram_engine.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/histogram_engine.sv
// histogram_engine: streaming pixel histogram with saturating per-bin counters.
// Flow per frame: clear all bins, accumulate N_PIXELS pixels through a
// 2-stage read/increment/write pipeline with forwarding, then drain
// {bin, count} words over a valid/ready handshake.
// Optional macro HIST_CUMULATIVE_EN: drained count becomes the running
// saturating sum of bins 0..b (CDF) instead of the per-bin count.
module histogram_engine #(
    parameter int unsigned PIXEL_W  = 8,
    parameter int unsigned BIN_W    = 8,
    parameter int unsigned COUNT_W  = 24,
    parameter int unsigned N_PIXELS = 76800
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [PIXEL_W-1:0]       veri_i,
    input  logic                     veri_valid_i,
    output logic                     veri_al_o,
    output logic [BIN_W+COUNT_W-1:0] veri_o,
    output logic                     veri_gonder_o,
    input  logic                     veri_hazir_i,
    output logic                     islem_bitti_o,
    output logic                     mesgul_o
);

    localparam int unsigned BIN_COUNT = 2 ** BIN_W;
    localparam int unsigned SHIFT     = PIXEL_W - BIN_W;
    localparam int unsigned PCNT_W    = 24;
    localparam int unsigned WORD_W    = BIN_W + COUNT_W;

    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [BIN_W-1:0]   BIN_LAST = {BIN_W{1'b1}};
    localparam logic [PCNT_W-1:0]  PIX_LAST = PCNT_W'(N_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [BIN_W-1:0]    clr_addr_q;
    logic [PCNT_W-1:0]   pix_cnt_q;
    logic                flush_q;
    logic [BIN_W-1:0]    rd_addr_q;
    logic                al_q;
    logic                gonder_q;
    logic [WORD_W-1:0]   out_q;
    logic                bitti_q;
    logic                mesgul_q;

    logic                s1_valid_q;
    logic [BIN_W-1:0]    s1_bin_q;
    logic                s2_valid_q;
    logic [BIN_W-1:0]    s2_bin_q;
    logic [COUNT_W-1:0]  s2_cnt_q;

    logic [COUNT_W-1:0]  mem_q [BIN_COUNT];

    logic                accept_c;
    logic [BIN_W-1:0]    pix_bin_c;
    logic [COUNT_W-1:0]  s1_rd_c;
    logic [COUNT_W-1:0]  s1_inc_c;
    logic [BIN_W-1:0]    ld_addr_c;
    logic [COUNT_W-1:0]  ld_raw_c;
    logic [COUNT_W-1:0]  ld_cnt_c;
    logic [BIN_W-1:0]    out_bin_c;
    logic                load_c;

`ifdef HIST_CUMULATIVE_EN
    logic [COUNT_W-1:0]  acc_q;
    logic [COUNT_W-1:0]  acc_base_c;
    logic [COUNT_W:0]    sum_c;
`endif

    // Bin select, pipeline read with forwarding, drain word selection
    always_comb begin
        accept_c  = veri_valid_i && al_q;
        pix_bin_c = BIN_W'(veri_i >> SHIFT);

        // Stage 2 holds the value about to land in mem; prefer it on a bin match
        s1_rd_c  = (s2_valid_q && (s2_bin_q == s1_bin_q)) ? s2_cnt_q : mem_q[s1_bin_q];
        s1_inc_c = (s1_rd_c == CNT_MAX) ? CNT_MAX : s1_rd_c + COUNT_W'(1);

        ld_addr_c = (state_q == S_DRAIN) ? rd_addr_q : '0;
        ld_raw_c  = (s2_valid_q && (s2_bin_q == ld_addr_c)) ? s2_cnt_q : mem_q[ld_addr_c];

`ifdef HIST_CUMULATIVE_EN
        acc_base_c = (state_q == S_DRAIN) ? acc_q : '0;
        sum_c      = {1'b0, acc_base_c} + {1'b0, ld_raw_c};
        ld_cnt_c   = sum_c[COUNT_W] ? CNT_MAX : sum_c[COUNT_W-1:0];
`else
        ld_cnt_c   = ld_raw_c;
`endif

        out_bin_c = out_q[WORD_W-1 -: BIN_W];
        load_c    = ((state_q == S_FLUSH) && flush_q) ||
                    ((state_q == S_DRAIN) && gonder_q && veri_hazir_i && (out_bin_c != BIN_LAST));
    end

    // Counter storage: clear sweep has priority over pipeline write-back
    always_ff @(posedge clk_i) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end else if (s2_valid_q) begin
            mem_q[s2_bin_q] <= s2_cnt_q;
        end
    end

    // Two-stage increment pipeline: stage 1 captures the bin, stage 2 the new count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_bin_q   <= '0;
            s2_cnt_q   <= '0;
        end else begin
            s1_valid_q <= accept_c;
            s1_bin_q   <= pix_bin_c;
            s2_valid_q <= s1_valid_q;
            s2_bin_q   <= s1_bin_q;
            s2_cnt_q   <= s1_inc_c;
        end
    end

    // Frame control FSM with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            clr_addr_q <= '0;
            pix_cnt_q  <= '0;
            flush_q    <= 1'b0;
            rd_addr_q  <= '0;
            al_q       <= 1'b0;
            gonder_q   <= 1'b0;
            out_q      <= '0;
            bitti_q    <= 1'b0;
            mesgul_q   <= 1'b0;
`ifdef HIST_CUMULATIVE_EN
            acc_q      <= '0;
`endif
        end else begin
            bitti_q <= 1'b0;

            if (load_c) begin
                out_q     <= {ld_addr_c, ld_cnt_c};
                rd_addr_q <= ld_addr_c + BIN_W'(1);
`ifdef HIST_CUMULATIVE_EN
                acc_q     <= ld_cnt_c;
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_CLEAR;
                        clr_addr_q <= '0;
                        mesgul_q   <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + BIN_W'(1);
                    if (clr_addr_q == BIN_LAST) begin
                        state_q   <= S_ACCUM;
                        pix_cnt_q <= '0;
                        al_q      <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (accept_c) begin
                        pix_cnt_q <= pix_cnt_q + PCNT_W'(1);
                        if (pix_cnt_q == PIX_LAST) begin
                            al_q    <= 1'b0;
                            flush_q <= 1'b0;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    flush_q <= 1'b1;
                    if (flush_q) begin
                        state_q  <= S_DRAIN;
                        gonder_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (gonder_q && veri_hazir_i && (out_bin_c == BIN_LAST)) begin
                        gonder_q <= 1'b0;
                        bitti_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    mesgul_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign veri_al_o     = al_q;
    assign veri_o        = out_q;
    assign veri_gonder_o = gonder_q;
    assign islem_bitti_o = bitti_q;
    assign mesgul_o      = mesgul_q;

endmodule
